// File: rtl/display_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_pkg
// Shared definitions for the 4-digit 7-segment scan controller:
//   - glyph codes understood by the downstream 7-segment decoder
//     (values 0-9 are plain digits; the codes below are letters/blank)
//   - scan FSM state encoding
//   - small helpers for digit enables and the count plausibility check
// -----------------------------------------------------------------------------
package display_scan_ctrl_pkg;

  localparam logic [3:0] CODE_L     = 4'hA;
  localparam logic [3:0] CODE_O     = 4'hB;
  localparam logic [3:0] CODE_E     = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // One-hot digit enable for digit index sel (bit i = digit i).
  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

  // A count pair is implausible if either value or their sum exceeds one
  // decimal digit; the sum is taken 5 bits wide so 15+15 cannot wrap.
  function automatic logic counts_bad(input logic [3:0] f, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, f} + {1'b0, b};
    return (f > 4'd9) || (b > 4'd9) || (sum > 5'd9);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_if
// Bundle between the parking-slot counters, the scan controller and the
// 7-segment decoder / digit drivers.
//   free       4  number of free slots (binary)
//   busy       4  number of occupied slots (binary)
//   code       4  nibble for the segment decoder (digit value or glyph code)
//   digit_sel  2  index of the digit owning the current slot (0..3)
//   dig_on     4  one-hot active-high digit enable, all 0 when blanked
//   frame_strb 1  1-cycle pulse on the cycle the free/busy snapshot is taken
// Modports:
//   master : the scan controller (consumes counts, drives display signals)
//   slave  : the surrounding system (supplies counts, consumes display signals)
// -----------------------------------------------------------------------------
interface display_scan_ctrl_if;
  logic [3:0] free;
  logic [3:0] busy;
  logic [3:0] code;
  logic [1:0] digit_sel;
  logic [3:0] dig_on;
  logic       frame_strb;

  modport master (
    input  free, busy,
    output code, digit_sel, dig_on, frame_strb
  );

  modport slave (
    output free, busy,
    input  code, digit_sel, dig_on, frame_strb
  );
endinterface

// File: rtl/display_scan_ctrl_scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Slot counter for the display scan. Counts 0..SCAN_DIV-1 while run is high
// and wraps; holds its value while run is low.
//   clk        system clock
//   rst_n      asynchronous active-low reset (counter -> 0)
//   run        advance the counter this cycle
//   show_phase 1 when the NEXT cycle's count lies in the display window
//              (0 .. SCAN_DIV-BLANK_CYC-1); lets the registered FSM land
//              exactly on the phase boundaries
//   slot_end   1-cycle pulse on the last count of a slot
// -----------------------------------------------------------------------------
module scan_timer
  import display_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic show_phase,
  output logic slot_end
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] SHOW_CYC = CNT_W'(SCAN_DIV - BLANK_CYC);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (run) begin
      cnt_next = (cnt_reg == LAST_CNT) ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign show_phase = (cnt_next < SHOW_CYC);
  assign slot_end   = run && (cnt_reg == LAST_CNT);

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Scan scheduler for the 4-digit common-anode 7-segment display of the
// parking-slot system. Time-shares one segment decoder over four digits,
// inserts an all-off dead-time at the end of every digit slot, snapshots the
// free/busy counts once per frame and blinks the display while the car park
// is full.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   disp   display_scan_ctrl_if.master (free/busy in; code, digit_sel,
//          dig_on, frame_strb out -- all outputs registered)
// Digit layout: d0 = free, d1 = 'L', d2 = busy, d3 = 'O'; d0/d2 show 'E'
// when the snapshot is implausible.
// -----------------------------------------------------------------------------
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  display_scan_ctrl_if.master   disp
);

  localparam int FCNT_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [FCNT_W-1:0] BLINK_LEN = FCNT_W'(BLINK_FRAMES);

  scan_state_t       state_reg, state_next;
  logic [1:0]        digit_sel_reg, digit_sel_next;
  logic [3:0]        free_q_reg, free_q_next;
  logic [3:0]        busy_q_reg, busy_q_next;
  logic [FCNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic              blink_off_reg, blink_off_next;
  logic [3:0]        dig_on_reg, dig_on_next;
  logic [3:0]        code_reg, code_next;
  logic              frame_strb_reg, frame_strb_next;

  logic show_phase;
  logic slot_end;
  logic start_frame;
  logic snap_bad;
  logic entering_show;

  scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (state_reg != IDLE),
    .show_phase (show_phase),
    .slot_end   (slot_end)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: phase boundaries come from the timer's look-ahead.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    state_next = SHOW;
      SHOW:    if (!show_phase) state_next = BLANK;
      BLANK:   if (show_phase)  state_next = SHOW;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    // A new frame begins when leaving IDLE or when digit 3's slot ends.
    start_frame = (state_reg == IDLE) || (slot_end && (digit_sel_reg == 2'd3));

    digit_sel_next = slot_end ? digit_sel_reg + 2'd1 : digit_sel_reg;

    free_q_next = start_frame ? disp.free : free_q_reg;
    busy_q_next = start_frame ? disp.busy : busy_q_reg;
    snap_bad    = counts_bad(free_q_next, busy_q_next);

    // frame_cnt holds how many frames of the current blink half-period have
    // already been started; a cleared counter means no blinking in progress.
    frame_cnt_next = frame_cnt_reg;
    blink_off_next = blink_off_reg;
    if (start_frame) begin
      if ((free_q_next == 4'd0) && !snap_bad) begin
        if (frame_cnt_reg == BLINK_LEN) begin
          blink_off_next = ~blink_off_reg;
          frame_cnt_next = FCNT_W'(1);
        end else begin
          frame_cnt_next = frame_cnt_reg + 1'b1;
        end
      end else begin
        blink_off_next = 1'b0;
        frame_cnt_next = '0;
      end
    end

    // Content is computed from the snapshot being taken this cycle, so the
    // first slot of a frame already shows the fresh values.
    entering_show = (state_next == SHOW) && (state_reg != SHOW);
    code_next = code_reg;
    if (entering_show) begin
      unique case (digit_sel_next)
        2'd0:    code_next = snap_bad ? CODE_E : free_q_next;
        2'd1:    code_next = CODE_L;
        2'd2:    code_next = snap_bad ? CODE_E : busy_q_next;
        default: code_next = CODE_O;
      endcase
    end

    dig_on_next = ((state_next == SHOW) && !blink_off_next) ? onehot4(digit_sel_next) : 4'b0000;

    frame_strb_next = start_frame;
  end

  // Datapath / output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel_reg  <= 2'd0;
      free_q_reg     <= 4'd0;
      busy_q_reg     <= 4'd0;
      frame_cnt_reg  <= '0;
      blink_off_reg  <= 1'b0;
      dig_on_reg     <= 4'b0000;
      code_reg       <= CODE_BLANK;
      frame_strb_reg <= 1'b0;
    end else begin
      digit_sel_reg  <= digit_sel_next;
      free_q_reg     <= free_q_next;
      busy_q_reg     <= busy_q_next;
      frame_cnt_reg  <= frame_cnt_next;
      blink_off_reg  <= blink_off_next;
      dig_on_reg     <= dig_on_next;
      code_reg       <= code_next;
      frame_strb_reg <= frame_strb_next;
    end
  end

  assign disp.code       = code_reg;
  assign disp.digit_sel  = digit_sel_reg;
  assign disp.dig_on     = dig_on_reg;
  assign disp.frame_strb = frame_strb_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Self-checking bench for display_scan_ctrl. The reference model works in
// terms of elapsed cycles since the first display cycle: frame, slot and
// position are plain divisions, the snapshot is whatever was applied at the
// frame's first edge, and the blink phase follows from how many consecutive
// "full" frames have been shown.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int SCAN_DIV     = 20;
  localparam int BLANK_CYC    = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 4 * SCAN_DIV;
  localparam int SHOW_LEN     = SCAN_DIV - BLANK_CYC;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  display_scan_ctrl_if disp_if ();

  display_scan_ctrl #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYC    (BLANK_CYC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .disp  (disp_if)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // model state
  int         t;          // cycles since first display cycle (-1 = before it)
  int         cyc;        // absolute checked-cycle count
  int         last_strb;
  int         run_len;    // consecutive frames with a "full" snapshot
  int         frame_no;
  bit         blink_off;
  logic [3:0] applied_free, applied_busy;
  logic [3:0] snap_free, snap_busy;
  logic [1:0] prev_sel;
  logic [3:0] prev_dig_on;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic [3:0] model_code(input int slot);
    int  sum;
    bit  bad;
    sum = int'(snap_free) + int'(snap_busy);
    bad = (snap_free > 9) || (snap_busy > 9) || (sum > 9);
    case (slot)
      0:       return bad ? 4'hE : snap_free;
      1:       return 4'hA;
      2:       return bad ? 4'hE : snap_busy;
      default: return 4'hB;
    endcase
  endfunction

  // Entered on a negedge: applies inputs, checks the cycle after the next
  // posedge, returns on the following negedge.
  task automatic step(input logic [3:0] f, input logic [3:0] b);
    int         slot, pos, sum;
    bit         bad, full;
    logic [3:0] exp_on;
    disp_if.free = f;
    disp_if.busy = b;
    applied_free = f;
    applied_busy = b;
    @(posedge clk);
    #1;
    cyc++;
    t++;
    if (t % FRAME == 0) begin
      snap_free = applied_free;
      snap_busy = applied_busy;
      sum  = int'(snap_free) + int'(snap_busy);
      bad  = (snap_free > 9) || (snap_busy > 9) || (sum > 9);
      full = (snap_free == 0) && !bad;
      run_len   = full ? run_len + 1 : 0;
      blink_off = full && ((((run_len - 1) / BLINK_FRAMES) % 2) == 1);
      frame_no++;
      $display("frame %0d: free=%0d busy=%0d blink_off=%0d", frame_no, snap_free, snap_busy, blink_off);
    end
    slot   = (t % FRAME) / SCAN_DIV;
    pos    = t % SCAN_DIV;
    exp_on = ((pos < SHOW_LEN) && !blink_off) ? 4'(1 << slot) : 4'b0000;

    check("dig_on",     {28'd0, disp_if.dig_on},     {28'd0, exp_on});
    check("code",       {28'd0, disp_if.code},       {28'd0, model_code(slot)});
    check("digit_sel",  {30'd0, disp_if.digit_sel},  slot);
    check("frame_strb", {31'd0, disp_if.frame_strb}, (pos == 0 && slot == 0) ? 1 : 0);
    check("onehot0",    {31'd0, $onehot0(disp_if.dig_on)}, 1);
    if (disp_if.digit_sel != prev_sel)
      check("sel_chg_dark", {28'd0, prev_dig_on}, 0);
    if (disp_if.frame_strb) begin
      if (last_strb >= 0)
        check("frame_period", cyc - last_strb, FRAME);
      last_strb = cyc;
    end
    prev_sel    = disp_if.digit_sel;
    prev_dig_on = disp_if.dig_on;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [3:0] f, input logic [3:0] b);
    for (int i = 0; i < n; i++) step(f, b);
  endtask

  // Asserts reset without any clock edge, checks outputs, releases on a negedge.
  task automatic do_reset(input logic [3:0] f, input logic [3:0] b);
    rst_n = 1'b0;
    #1;
    check("rst_dig_on",     {28'd0, disp_if.dig_on},     0);
    check("rst_code",       {28'd0, disp_if.code},       32'hF);
    check("rst_digit_sel",  {30'd0, disp_if.digit_sel},  0);
    check("rst_frame_strb", {31'd0, disp_if.frame_strb}, 0);
    disp_if.free = f;
    disp_if.busy = b;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    t           = -1;
    run_len     = 0;
    blink_off   = 1'b0;
    last_strb   = -1;
    prev_sel    = 2'd0;
    prev_dig_on = 4'd0;
  endtask

  initial begin
    logic [3:0] rf, rb;
    bit         found;
    int         n;
    cyc = 0; frame_no = 0; t = -1;
    disp_if.free = 4'd0;
    disp_if.busy = 4'd0;
    #2;
    do_reset(4'd3, 4'd5);

    // basic scan, then free 3->4 during slot 1 of the second frame
    run(FRAME, 4'd3, 4'd5);
    run(30, 4'd3, 4'd5);
    run(FRAME - 30 + FRAME, 4'd4, 4'd5);

    // full car park: blink, then steady again
    run(6 * FRAME, 4'd0, 4'd9);
    run(2 * FRAME, 4'd1, 4'd8);

    // implausible counts
    run(2 * FRAME, 4'd7, 4'd6);
    run(2 * FRAME, 4'd12, 4'd6);

    // randomized runs of varying length, often "full"
    for (int k = 0; k < 16; k++) begin
      rf = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 12));
      n  = $urandom_range(20, 260);
      run(n, rf, rb);
    end

    // reset in the middle of digit 2's display window
    found = 1'b0;
    rf = 4'($urandom_range(1, 5));
    rb = 4'($urandom_range(0, 4));
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step(rf, rb);
      if (((t % FRAME) / SCAN_DIV == 2) && (t % SCAN_DIV == 5)) found = 1'b1;
    end
    check("reach_digit2_show", {31'd0, found}, 1);
    rf = 4'($urandom_range(0, 9));
    do_reset(rf, 4'd0);
    run(3 * FRAME, rf, 4'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
